// File: rtl/memory_unit.sv
// ---------------------------------------------------------------------------
// memory_unit
//   Load/store execution unit behind the reservation station's memory issue
//   port. Effective address = value1 + imm (32-bit wrap). Each access moves
//   one byte per cycle over an 8-bit synchronous RAM port (1-cycle read
//   latency), little-endian. The finished op is broadcast on the CDB for one
//   cycle; memory_busy holds off further issues while an op is in flight.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous squash (branch mispredict)
//   memory_op       LB/LH/LW/LBU/LHU/SB/SH/SW opcode
//   memory_value1   base register value
//   memory_value2   store data (ignored for loads)
//   memory_imm      address offset
//   memory_des      issue tag, nonzero = issue this cycle
//   mem_din         RAM read data
//   mem_a           RAM byte address
//   mem_dout        RAM write data
//   mem_wr          RAM write enable
//   memory_busy     unit occupied, RS must not issue
//   result_data     CDB data (extended load value, 0 for stores)
//   result_des      CDB tag, nonzero for one cycle per completed op
// ---------------------------------------------------------------------------
module memory_unit #(
    parameter int TAG_WIDTH  = 3,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [4:0]            memory_op,
    input  logic [31:0]           memory_value1,
    input  logic [31:0]           memory_value2,
    input  logic [31:0]           memory_imm,
    input  logic [TAG_WIDTH-1:0]  memory_des,
    input  logic [7:0]            mem_din,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    output logic                  memory_busy,
    output logic [31:0]           result_data,
    output logic [TAG_WIDTH-1:0]  result_des
);

    localparam logic [4:0] OP_LB  = 5'b10010;
    localparam logic [4:0] OP_LH  = 5'b10011;
    localparam logic [4:0] OP_LW  = 5'b10100;
    localparam logic [4:0] OP_LBU = 5'b10101;
    localparam logic [4:0] OP_LHU = 5'b10110;
    localparam logic [4:0] OP_SB  = 5'b10111;
    localparam logic [4:0] OP_SH  = 5'b11000;
    localparam logic [4:0] OP_SW  = 5'b11001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_TAIL,
        S_DONE
    } state_t;

    state_t                 state;
    logic [4:0]             op_r;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [31:0]            addr_r;
    logic [31:0]            store_r;
    logic [31:0]            buf_r;
    logic [2:0]             cnt;      // bytes already presented on mem_a
    logic                   squash;   // store flushed mid-flight: finish writes, no broadcast

    logic [31:0]            eff_addr;
    logic                   accept_ok;
    logic                   is_store;
    logic [2:0]             n_bytes;
    logic [1:0]             rd_idx;
    logic [1:0]             tail_idx;
    logic [31:0]            next_addr;
    logic [31:0]            load_val;

    function automatic logic op_is_store(input logic [4:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] op_size(input logic [4:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] byte_put(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (i)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    always_comb begin
        eff_addr  = memory_value1 + memory_imm;
        accept_ok = (memory_des != '0) && (memory_op >= OP_LB) && (memory_op <= OP_SW) && !flush;
        is_store  = op_is_store(op_r);
        n_bytes   = op_size(op_r);
        // Read data for the byte addressed two edges ago arrives now.
        rd_idx    = 2'(cnt - 3'd2);
        tail_idx  = 2'(n_bytes - 3'd1);
        next_addr = addr_r + {29'd0, cnt};
        case (op_r)
            OP_LB:   load_val = {{24{buf_r[7]}}, buf_r[7:0]};
            OP_LH:   load_val = {{16{buf_r[15]}}, buf_r[15:0]};
            OP_LW:   load_val = buf_r;
            OP_LBU:  load_val = {24'd0, buf_r[7:0]};
            OP_LHU:  load_val = {16'd0, buf_r[15:0]};
            default: load_val = '0;
        endcase
    end

    // Registered state only, so busy cannot glitch.
    assign memory_busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_r        <= '0;
            tag_r       <= '0;
            addr_r      <= '0;
            store_r     <= '0;
            buf_r       <= '0;
            cnt         <= '0;
            squash      <= 1'b0;
            mem_a       <= '0;
            mem_dout    <= '0;
            mem_wr      <= 1'b0;
            result_data <= '0;
            result_des  <= '0;
        end else begin
            result_des <= '0;
            case (state)
                S_IDLE: begin
                    if (accept_ok) begin
                        op_r    <= memory_op;
                        tag_r   <= memory_des;
                        addr_r  <= eff_addr;
                        store_r <= memory_value2;
                        buf_r   <= '0;
                        cnt     <= 3'd1;
                        squash  <= 1'b0;
                        mem_a   <= eff_addr[ADDR_WIDTH-1:0];
                        if (op_is_store(memory_op)) begin
                            mem_wr   <= 1'b1;
                            mem_dout <= memory_value2[7:0];
                        end
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!is_store && flush) begin
                        state <= S_IDLE;
                    end else begin
                        // A flushed store keeps writing so memory is never torn.
                        if (is_store && flush) begin
                            squash <= 1'b1;
                        end
                        if (!is_store && cnt >= 3'd2) begin
                            buf_r <= byte_put(buf_r, rd_idx, mem_din);
                        end
                        if (cnt == n_bytes) begin
                            mem_wr <= 1'b0;
                            state  <= is_store ? S_DONE : S_TAIL;
                        end else begin
                            mem_a <= next_addr[ADDR_WIDTH-1:0];
                            if (is_store) begin
                                mem_dout <= byte_sel(store_r, cnt[1:0]);
                            end
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_TAIL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        buf_r <= byte_put(buf_r, tail_idx, mem_din);
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Broadcast is registered out of DONE, so it is visible in
                    // the cycle after leaving DONE and busy is already low then.
                    state <= S_IDLE;
                    if (!flush && !squash) begin
                        result_des  <= tag_r;
                        result_data <= load_val;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
module tb_memory_unit;

    localparam logic [4:0] LB  = 5'b10010;
    localparam logic [4:0] LH  = 5'b10011;
    localparam logic [4:0] LW  = 5'b10100;
    localparam logic [4:0] LBU = 5'b10101;
    localparam logic [4:0] LHU = 5'b10110;
    localparam logic [4:0] SB  = 5'b10111;
    localparam logic [4:0] SH  = 5'b11000;
    localparam logic [4:0] SW  = 5'b11001;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  memory_op;
    logic [31:0] memory_value1, memory_value2, memory_imm;
    logic [2:0]  memory_des;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        memory_busy;
    logic [31:0] result_data;
    logic [2:0]  result_des;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] ram [logic [31:0]];
    logic [2:0]  obs_tag[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [31:0] wr_a[$];
    logic [7:0]  wr_d[$];
    int          wr_c[$];

    memory_unit #(.TAG_WIDTH(3), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .memory_op(memory_op), .memory_value1(memory_value1),
        .memory_value2(memory_value2), .memory_imm(memory_imm),
        .memory_des(memory_des), .mem_din(mem_din), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .memory_busy(memory_busy),
        .result_data(result_data), .result_des(result_des)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_ram(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // Synchronous byte RAM with one cycle of read latency; logs writes.
    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            ram[mem_a] = mem_dout;
            wr_a.push_back(mem_a);
            wr_d.push_back(mem_dout);
            wr_c.push_back(cyc);
        end
        mem_din <= rd_ram(mem_a);
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (result_des !== 3'd0) begin
            obs_tag.push_back(result_des);
            obs_data.push_back(result_data);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int op_len(input logic [4:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    // Reference load value: assemble bytes, then extend arithmetically.
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] addr);
        longint v;
        int n;
        v = 0;
        n = op_len(op);
        for (int i = 0; i < n; i++) v += longint'(rd_ram(addr + 32'(i))) << (8 * i);
        if ((op == LB || op == LH) && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic clear_logs();
        obs_tag.delete(); obs_data.delete(); obs_cyc.delete();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
    endtask

    task automatic at_edge(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [2:0] tag, input logic fl,
                         output int e0);
        @(negedge clk);
        memory_op = op; memory_value1 = v1; memory_value2 = v2;
        memory_imm = imm; memory_des = tag; flush = fl;
        @(posedge clk);
        #1;
        e0 = cyc;
        memory_des = 3'd0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (memory_busy !== 1'b0 || mem_wr !== 1'b0 || result_des !== 3'd0 ||
            mem_a !== 32'd0 || mem_dout !== 8'd0 || result_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b wr=%b des=%0d a=%h dout=%h data=%h, want all 0",
                     memory_busy, mem_wr, result_des, mem_a, mem_dout, result_data);
        end
    endtask

    task automatic test_lw();
        int e0;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        clear_logs();
        issue(LW, 32'h100, 32'h0, 32'h0, 3'd5, 1'b0, e0);
        for (int c = 0; c < 4; c++) begin
            at_edge(e0 + c);
            checks++;
            if (mem_a !== 32'h100 + 32'(c) || mem_wr !== 1'b0 || memory_busy !== 1'b1) begin
                errors++;
                $display("FAIL lw_addr c=%0d: a=%h wr=%b busy=%b, want a=%h wr=0 busy=1",
                         c, mem_a, mem_wr, memory_busy, 32'h100 + 32'(c));
            end
        end
        at_edge(e0 + 5);
        checks++;
        if (result_des !== 3'd0) begin
            errors++;
            $display("FAIL lw_early: result_des=%0d at E0+5, want 0", result_des);
        end
        at_edge(e0 + 6);
        checks++;
        if (result_des !== 3'd5 || result_data !== 32'h44332211) begin
            errors++;
            $display("FAIL lw_result: des=%0d data=%h, want 5 44332211", result_des, result_data);
        end
        at_edge(e0 + 7);
        checks++;
        if (result_des !== 3'd0 || memory_busy !== 1'b0 || obs_tag.size() != 1) begin
            errors++;
            $display("FAIL lw_end: des=%0d busy=%b broadcasts=%0d, want 0 0 1",
                     result_des, memory_busy, obs_tag.size());
        end
    endtask

    task automatic test_ext();
        int e0;
        logic [31:0] got;
        ram[32'hFF] = 8'h80;
        ram[32'h300] = 8'h01; ram[32'h301] = 8'h80;
        for (int k = 0; k < 3; k++) begin
            clear_logs();
            if (k == 0) issue(LB, 32'h100, 32'h0, 32'hFFFF_FFFF, 3'd1, 1'b0, e0);
            else if (k == 1) issue(LBU, 32'h100, 32'h0, 32'hFFFF_FFFF, 3'd2, 1'b0, e0);
            else issue(LHU, 32'h300, 32'h0, 32'h0, 3'd3, 1'b0, e0);
            at_edge(e0 + 8);
            got = (obs_data.size() > 0) ? obs_data[0] : 32'hXXXX_XXXX;
            checks++;
            if (obs_tag.size() != 1 || got !== (k == 0 ? 32'hFFFF_FF80 : k == 1 ? 32'h0000_0080
                                                          : 32'h0000_8001)) begin
                errors++;
                $display("FAIL ext k=%0d: broadcasts=%0d data=%h", k, obs_tag.size(), got);
            end
        end
    endtask

    task automatic test_sh();
        int e0;
        ram[32'h203] = 8'h00; ram[32'h204] = 8'h00; ram[32'h205] = 8'h5A;
        clear_logs();
        issue(SH, 32'h200, 32'hABCD_1234, 32'h3, 3'd3, 1'b0, e0);
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h203 || mem_dout !== 8'h34) begin
            errors++;
            $display("FAIL sh_b0: wr=%b a=%h dout=%h, want 1 203 34", mem_wr, mem_a, mem_dout);
        end
        at_edge(e0 + 1);
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h204 || mem_dout !== 8'h12) begin
            errors++;
            $display("FAIL sh_b1: wr=%b a=%h dout=%h, want 1 204 12", mem_wr, mem_a, mem_dout);
        end
        at_edge(e0 + 2);
        checks++;
        if (mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL sh_wr_off: wr=%b, want 0", mem_wr);
        end
        at_edge(e0 + 3);
        checks++;
        if (result_des !== 3'd3 || result_data !== 32'd0) begin
            errors++;
            $display("FAIL sh_result: des=%0d data=%h, want 3 0", result_des, result_data);
        end
        at_edge(e0 + 4);
        checks++;
        if (memory_busy !== 1'b0 || wr_a.size() != 2 || ram[32'h203] !== 8'h34 ||
            ram[32'h204] !== 8'h12 || ram[32'h205] !== 8'h5A) begin
            errors++;
            $display("FAIL sh_mem: busy=%b writes=%0d ram=%h %h %h, want 0 2 34 12 5a",
                     memory_busy, wr_a.size(), ram[32'h203], ram[32'h204], ram[32'h205]);
        end
    endtask

    task automatic test_random();
        int e0, n, exp_c;
        logic [4:0] op;
        logic [31:0] addr, v1, v2, exp_d;
        logic [2:0] tag;
        logic st;
        for (int it = 0; it < 40; it++) begin
            op   = LB + 5'($urandom_range(0, 7));
            addr = (it % 5 == 0) ? 32'hFFFF_FFFE : $urandom;
            v1   = $urandom;
            v2   = $urandom;
            tag  = 3'($urandom_range(1, 7));
            n    = op_len(op);
            st   = (op >= SB);
            if (!st) for (int i = 0; i < n; i++) ram[addr + 32'(i)] = 8'($urandom);
            exp_d = st ? 32'd0 : ref_load(op, addr);
            exp_c = st ? n + 1 : n + 2;
            clear_logs();
            issue(op, v1, v2, addr - v1, tag, 1'b0, e0);
            at_edge(e0 + n + 3);
            checks++;
            if (obs_tag.size() != 1 || obs_tag[0] !== tag || obs_data[0] !== exp_d ||
                obs_cyc[0] != e0 + exp_c || memory_busy !== 1'b0) begin
                errors++;
                $display("FAIL rand it=%0d op=%b: n_bc=%0d tag=%0d data=%h dt=%0d busy=%b, want %0d %h %0d 0",
                         it, op, obs_tag.size(), obs_tag.size() ? obs_tag[0] : 3'd0,
                         obs_data.size() ? obs_data[0] : 32'd0,
                         obs_cyc.size() ? obs_cyc[0] - e0 : -1, memory_busy, tag, exp_d, exp_c);
            end
            checks++;
            if (wr_a.size() != (st ? n : 0)) begin
                errors++;
                $display("FAIL rand_wcount it=%0d: writes=%0d want %0d", it, wr_a.size(), st ? n : 0);
            end else if (st) begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wr_a[i] !== addr + 32'(i) || wr_d[i] !== 8'(v2 >> (8 * i)) ||
                        wr_c[i] != e0 + i) begin
                        errors++;
                        $display("FAIL rand_wr it=%0d b=%0d: a=%h d=%h dt=%0d want %h %h %0d",
                                 it, i, wr_a[i], wr_d[i], wr_c[i] - e0, addr + 32'(i),
                                 8'(v2 >> (8 * i)), i);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        ram[32'h100] = 8'hA1; ram[32'h101] = 8'hB2; ram[32'h102] = 8'hC3; ram[32'h103] = 8'hD4;
        clear_logs();
        @(negedge clk);
        memory_op = LW; memory_value1 = 32'h100; memory_value2 = 32'h0;
        memory_imm = 32'h0; memory_des = 3'd1;
        @(posedge clk);
        #1;
        e0 = cyc;
        memory_op = SB; memory_value1 = 32'h400; memory_value2 = 32'h0000_0077;
        memory_des = 3'd2;
        at_edge(e0 + 7);
        memory_des = 3'd0;
        at_edge(e0 + 12);
        checks++;
        if (obs_tag.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: broadcasts=%0d, want 2", obs_tag.size());
        end else begin
            checks++;
            if (obs_tag[0] !== 3'd1 || obs_data[0] !== 32'hD4C3B2A1 || obs_cyc[0] != e0 + 6 ||
                obs_tag[1] !== 3'd2 || obs_cyc[1] != e0 + 9) begin
                errors++;
                $display("FAIL b2b_order: tags=%0d,%0d data0=%h dt=%0d,%0d want 1,2 d4c3b2a1 6,9",
                         obs_tag[0], obs_tag[1], obs_data[0], obs_cyc[0] - e0, obs_cyc[1] - e0);
            end
        end
        checks++;
        if (wr_a.size() != 1 || wr_a[0] !== 32'h400 || wr_d[0] !== 8'h77 || wr_c[0] != e0 + 7) begin
            errors++;
            $display("FAIL b2b_write: writes=%0d, want one write of 77 at 400 on E0+7", wr_a.size());
        end
    endtask

    task automatic test_invalid_and_idle_flush();
        int e0;
        clear_logs();
        issue(5'b00001, 32'h10, 32'h0, 32'h0, 3'd4, 1'b0, e0);
        issue(5'b11010, 32'h10, 32'h0, 32'h0, 3'd4, 1'b0, e0);
        checks++;
        if (memory_busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_busy: busy=%b, want 0", memory_busy);
        end
        issue(LB, 32'h10, 32'h0, 32'h0, 3'd6, 1'b1, e0);
        checks++;
        if (memory_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush_busy: busy=%b, want 0", memory_busy);
        end
        at_edge(e0 + 6);
        checks++;
        if (obs_tag.size() != 0 || wr_a.size() != 0) begin
            errors++;
            $display("FAIL invalid_bcast: broadcasts=%0d writes=%0d, want 0 0",
                     obs_tag.size(), wr_a.size());
        end
    endtask

    task automatic test_flush_lw();
        int e0;
        clear_logs();
        issue(LW, 32'h100, 32'h0, 32'h0, 3'd7, 1'b0, e0);
        at_edge(e0 + 1);
        flush = 1'b1;
        at_edge(e0 + 2);
        flush = 1'b0;
        at_edge(e0 + 3);
        checks++;
        if (memory_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_lw_busy: busy=%b after E0+3, want 0", memory_busy);
        end
        at_edge(e0 + 9);
        checks++;
        if (obs_tag.size() != 0 || wr_a.size() != 0) begin
            errors++;
            $display("FAIL flush_lw: broadcasts=%0d writes=%0d, want 0 0", obs_tag.size(), wr_a.size());
        end
    endtask

    task automatic test_flush_sw();
        int e0;
        for (int i = 0; i < 4; i++) ram[32'h500 + 32'(i)] = 8'h00;
        clear_logs();
        issue(SW, 32'h500, 32'hDEAD_BEEF, 32'h0, 3'd4, 1'b0, e0);
        flush = 1'b1;
        at_edge(e0 + 1);
        flush = 1'b0;
        at_edge(e0 + 8);
        checks++;
        if (obs_tag.size() != 0 || wr_a.size() != 4 || memory_busy !== 1'b0 ||
            ram[32'h500] !== 8'hEF || ram[32'h501] !== 8'hBE ||
            ram[32'h502] !== 8'hAD || ram[32'h503] !== 8'hDE) begin
            errors++;
            $display("FAIL flush_sw: broadcasts=%0d writes=%0d busy=%b ram=%h%h%h%h, want 0 4 0 deadbeef",
                     obs_tag.size(), wr_a.size(), memory_busy,
                     ram[32'h503], ram[32'h502], ram[32'h501], ram[32'h500]);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        clear_logs();
        issue(LW, 32'h100, 32'h0, 32'h0, 3'd5, 1'b0, e0);
        at_edge(e0 + 2);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (memory_busy !== 1'b0 || mem_wr !== 1'b0 || result_des !== 3'd0 ||
            mem_a !== 32'd0 || mem_dout !== 8'd0 || result_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b wr=%b des=%0d a=%h dout=%h data=%h, want all 0",
                     memory_busy, mem_wr, result_des, mem_a, mem_dout, result_data);
        end
        @(negedge clk);
        rst = 1'b0;
        at_edge(e0 + 10);
        checks++;
        if (obs_tag.size() != 0 || memory_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_bcast: broadcasts=%0d busy=%b, want 0 0",
                     obs_tag.size(), memory_busy);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; memory_op = '0; memory_value1 = '0;
        memory_value2 = '0; memory_imm = '0; memory_des = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_lw();
        test_ext();
        test_sh();
        test_random();
        test_back_to_back();
        test_invalid_and_idle_flush();
        test_flush_lw();
        test_flush_sw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
